// File: rtl/dlx_icache_ctrl.sv
// Direct-mapped instruction cache for the DLX IF stage: 32 lines x 128 bits.
// Hits return in the same cycle; misses stall IF and refill the line as four 32-bit beats.
module dlx_icache_ctrl #(
  parameter int ADDR_W = 16,
  parameter int TAG_W  = 7,
  parameter int IDX_W  = 5,
  parameter int LINE_W = 128,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [WORD_W-1:0] o_if_instr,
  output logic              o_if_stall,
  input  logic              i_flush,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [WORD_W-1:0] i_mem_rdata
);

  localparam int LINES = 2 ** IDX_W;
  localparam int WORDS = LINE_W / WORD_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_UPDATE
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [WORDS-1:0][WORD_W-1:0] r_data [LINES];
  logic [TAG_W-1:0]             r_tag  [LINES];
  logic [LINES-1:0]             r_valid;
  logic [WORDS-1:0][WORD_W-1:0] r_lineBuf;
  logic [TAG_W-1:0]             r_ltag;
  logic [IDX_W-1:0]             r_lidx;
  logic [1:0]                   r_beat;
  logic                         r_flushPend;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_word;
  logic             w_hit;
  logic             w_unused;

  assign w_tag    = i_if_addr[ADDR_W-1 -: TAG_W];
  assign w_idx    = i_if_addr[4 +: IDX_W];
  assign w_word   = i_if_addr[3:2];
  assign w_unused = ^i_if_addr[1:0];

  // A flush in the same cycle suppresses the hit so IF sees the invalidation at once.
  assign w_hit = i_if_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag)
               & (r_state == S_IDLE) & ~i_flush;

  always_comb begin
    w_stateNext = r_state;
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_if_stall  = (i_if_req & ~w_hit) | (r_state != S_IDLE);
    o_if_instr  = w_hit ? r_data[w_idx][w_word] : '0;
    case (r_state)
      S_IDLE: begin
        if (!i_flush && i_if_req && !w_hit) w_stateNext = S_REFILL;
      end
      S_REFILL: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {r_ltag, r_lidx, r_beat, 2'b00};
        if (i_mem_ack && (r_beat == 2'd3)) w_stateNext = S_UPDATE;
      end
      S_UPDATE: begin
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_beat      <= 2'd0;
      r_flushPend <= 1'b0;
      r_valid     <= '0;
      r_ltag      <= '0;
      r_lidx      <= '0;
    end else begin
      r_state <= w_stateNext;
      case (r_state)
        S_IDLE: begin
          if (i_flush) begin
            r_valid <= '0;
          end else if (i_if_req && !w_hit) begin
            r_ltag <= w_tag;
            r_lidx <= w_idx;
            r_beat <= 2'd0;
          end
        end
        S_REFILL: begin
          if (i_flush) r_flushPend <= 1'b1;
          if (i_mem_ack) r_beat <= r_beat + 2'd1;
        end
        S_UPDATE: begin
          // A flush seen at any point of the refill leaves the new line invalid too.
          if (r_flushPend || i_flush) begin
            r_valid     <= '0;
            r_flushPend <= 1'b0;
          end else begin
            r_valid[r_lidx] <= 1'b1;
          end
        end
        default: begin
          r_flushPend <= 1'b0;
        end
      endcase
    end
  end

  // Line storage carries no reset; valid bits alone decide whether contents are used.
  always_ff @(posedge clk) begin
    if ((r_state == S_REFILL) && i_mem_ack) r_lineBuf[r_beat] <= i_mem_rdata;
    if (r_state == S_UPDATE) begin
      r_data[r_lidx] <= r_lineBuf;
      r_tag[r_lidx]  <= r_ltag;
    end
  end

endmodule

// File: tb/tb_dlx_icache_ctrl.sv
// Self-checking bench for dlx_icache_ctrl: directed scenarios plus random fetch/flush
// traffic compared every cycle against a line-level cache model.
module tb_dlx_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifReq = 1'b0;
  logic [15:0] ifAddr = 16'h0;
  logic        flushIn = 1'b0;
  logic        memAck = 1'b0;
  logic [31:0] memRdata = 32'h0;
  logic [31:0] ifInstr;
  logic        ifStall;
  logic        memReq;
  logic [15:0] memAddr;

  dlx_icache_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_if_req   (ifReq),
    .i_if_addr  (ifAddr),
    .o_if_instr (ifInstr),
    .o_if_stall (ifStall),
    .i_flush    (flushIn),
    .o_mem_req  (memReq),
    .o_mem_addr (memAddr),
    .i_mem_ack  (memAck),
    .i_mem_rdata(memRdata)
  );

  always #5 clk = ~clk;

  logic [31:0] memArr [16384];
  bit          mValid [32];
  logic [6:0]  mTag [32];
  bit          mActive;
  bit          mPend;
  int          mAcks;
  logic [15:0] mBase;
  int          ackCnt;
  int          ackWait;
  int          fixedWait;
  bit          randAck;
  logic [15:0] ackLog [$];
  bit          lastStall;
  logic [31:0] lastInstr;
  int          testsRun = 0;
  int          testsFailed = 0;

  function automatic bit mHit(input logic [15:0] a);
    return mValid[a[8:4]] && (mTag[a[8:4]] == a[15:9]);
  endfunction

  task automatic modelReset();
    foreach (mValid[i]) mValid[i] = 1'b0;
    mActive = 1'b0;
    mPend   = 1'b0;
    mAcks   = 0;
    ackCnt  = 0;
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit req, input logic [15:0] addr, input bit fl);
    ifReq   = req;
    ifAddr  = addr;
    flushIn = fl;
  endtask

  // Memory answers the beat the model expects; ack after ackWait idle cycles per beat.
  task automatic driveAck();
    if (mActive && mAcks < 4) begin
      memRdata = memArr[int'(mBase[15:2]) + mAcks];
      if (ackCnt >= ackWait) memAck = 1'b1;
      else begin
        memAck = 1'b0;
        ackCnt++;
      end
    end else begin
      memAck   = 1'b0;
      memRdata = $urandom;
    end
  endtask

  task automatic checkOutput();
    bit          hitE;
    bit          stallE;
    bit          reqE;
    logic [31:0] instrE;
    logic [15:0] addrE;
    if (!mActive) begin
      hitE   = ifReq && !flushIn && mHit(ifAddr);
      stallE = ifReq && !hitE;
      instrE = hitE ? memArr[ifAddr[15:2]] : 32'h0;
      reqE   = 1'b0;
      addrE  = 16'h0;
    end else if (mAcks < 4) begin
      stallE = 1'b1;
      instrE = 32'h0;
      reqE   = 1'b1;
      addrE  = mBase + 16'(4 * mAcks);
    end else begin
      stallE = 1'b1;
      instrE = 32'h0;
      reqE   = 1'b0;
      addrE  = 16'h0;
    end
    checkValue("if_stall", 32'(ifStall), 32'(stallE));
    checkValue("if_instr", ifInstr, instrE);
    checkValue("mem_req", 32'(memReq), 32'(reqE));
    checkValue("mem_addr", 32'(memAddr), 32'(addrE));
  endtask

  task automatic modelUpdate();
    if (!mActive) begin
      if (flushIn) begin
        foreach (mValid[i]) mValid[i] = 1'b0;
      end else if (ifReq && !mHit(ifAddr)) begin
        mActive = 1'b1;
        mBase   = {ifAddr[15:4], 4'h0};
        mAcks   = 0;
        mPend   = 1'b0;
      end
    end else if (mAcks < 4) begin
      if (flushIn) mPend = 1'b1;
      if (memAck) begin
        mAcks++;
        ackCnt  = 0;
        ackWait = randAck ? int'($urandom_range(0, 2)) : fixedWait;
      end
    end else begin
      mTag[mBase[8:4]] = mBase[15:9];
      if (mPend || flushIn) begin
        foreach (mValid[i]) mValid[i] = 1'b0;
      end else begin
        mValid[mBase[8:4]] = 1'b1;
      end
      mActive = 1'b0;
      mPend   = 1'b0;
    end
  endtask

  task automatic step();
    driveAck();
    @(negedge clk);
    checkOutput();
    lastStall = ifStall;
    lastInstr = ifInstr;
    if (memAck && memReq) ackLog.push_back(memAddr);
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic runFetch(input logic [15:0] a, input int flushAt,
                          output int stalls, output logic [31:0] instr);
    int startLog;
    bit flushed;
    bit done;
    startLog = ackLog.size();
    flushed  = 1'b0;
    done     = 1'b0;
    stalls   = 0;
    instr    = 32'hDEAD_BEEF;
    for (int c = 0; c < 300 && !done; c++) begin
      applyStimulus(1'b1, a, flushAt >= 0 && !flushed && (ackLog.size() - startLog == flushAt));
      if (flushIn) flushed = 1'b1;
      step();
      flushIn = 1'b0;
      if (lastStall) stalls++;
      else begin
        done  = 1'b1;
        instr = lastInstr;
      end
    end
    if (!done) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL fetch_timeout: addr 0x%0h still stalled, expected completion", a);
    end
  endtask

  initial begin
    int          stalls;
    int          s;
    logic [31:0] instr;
    logic [6:0]  rt;
    logic [4:0]  ri;

    for (int i = 0; i < 16384; i++) memArr[i] = $urandom;
    for (int k = 0; k < 4; k++) memArr[16 + k] = 32'hA0 + 32'(k);
    foreach (mTag[i]) mTag[i] = 7'h0;
    modelReset();
    fixedWait = 0;
    ackWait   = 0;
    randAck   = 1'b0;

    // Reset state.
    @(negedge clk);
    checkValue("reset_stall", 32'(ifStall), 32'h0);
    checkValue("reset_instr", ifInstr, 32'h0);
    checkValue("reset_mem_req", 32'(memReq), 32'h0);
    checkValue("reset_mem_addr", 32'(memAddr), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Cold miss on 0x0040.
    runFetch(16'h0040, -1, stalls, instr);
    checkValue("cold_stalls", 32'(stalls), 32'd6);
    checkValue("cold_instr", instr, 32'hA0);
    checkValue("cold_beats", 32'(ackLog.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      checkValue("cold_beat_addr", 32'((k < ackLog.size()) ? ackLog[k] : 16'hFFFF),
                 32'h40 + 32'(4 * k));

    // Hit on the same line.
    runFetch(16'h004C, -1, stalls, instr);
    checkValue("hit_stalls", 32'(stalls), 32'd0);
    checkValue("hit_instr", instr, 32'hA3);

    // Conflict on index 4 with tag 1, then the original line misses again.
    s = ackLog.size();
    runFetch(16'h0240, -1, stalls, instr);
    checkValue("conflict_stalls", 32'(stalls), 32'd6);
    for (int k = 0; k < 4; k++)
      checkValue("conflict_beat_addr", 32'((s + k < ackLog.size()) ? ackLog[s + k] : 16'hFFFF),
                 32'h240 + 32'(4 * k));
    runFetch(16'h0040, -1, stalls, instr);
    checkValue("conflict_remiss_stalls", 32'(stalls), 32'd6);
    checkValue("conflict_remiss_instr", instr, 32'hA0);

    // Three wait states per beat.
    fixedWait = 3;
    ackWait   = 3;
    runFetch(16'h0080, -1, stalls, instr);
    checkValue("wait_stalls", 32'(stalls), 32'd18);
    fixedWait = 0;
    ackWait   = 0;

    // Flush in IDLE beats a same-cycle request, then the line misses.
    applyStimulus(1'b1, 16'h0040, 1'b1);
    step();
    flushIn = 1'b0;
    checkValue("flush_idle_stall", 32'(lastStall), 32'd1);
    runFetch(16'h0040, -1, stalls, instr);
    checkValue("flush_idle_stalls", 32'(stalls), 32'd6);

    // Flush during beat 2: refill completes, line stays invalid, immediate re-miss.
    s = ackLog.size();
    runFetch(16'h0080, 2, stalls, instr);
    checkValue("flush_refill_stalls", 32'(stalls), 32'd12);
    checkValue("flush_refill_beats", 32'(ackLog.size() - s), 32'd8);

    // Async reset while waiting on beat 1.
    s = ackLog.size();
    applyStimulus(1'b1, 16'h0100, 1'b0);
    for (int c = 0; c < 20 && ackLog.size() == s; c++) step();
    if (ackLog.size() == s) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL async_beat_timeout: no beat accepted, expected one");
    end
    memAck = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkValue("async_mem_req", 32'(memReq), 32'h0);
    checkValue("async_mem_addr", 32'(memAddr), 32'h0);
    checkValue("async_stall", 32'(ifStall), 32'h1);
    modelReset();
    #1 rst_n = 1'b1;
    runFetch(16'h0040, -1, stalls, instr);
    checkValue("post_reset_stalls", 32'(stalls), 32'd6);
    checkValue("post_reset_instr", instr, 32'hA0);

    // Random fetch/flush traffic with random wait states.
    randAck = 1'b1;
    ackWait = int'($urandom_range(0, 2));
    for (int c = 0; c < 3000; c++) begin
      if (!lastStall) begin
        rt = 7'($urandom_range(0, 3));
        ri = 5'($urandom_range(0, 7));
        applyStimulus($urandom_range(0, 3) != 0, {rt, ri, 4'($urandom)}, flushIn);
      end
      flushIn = !flushIn && ($urandom_range(0, 49) == 0);
      step();
    end
    applyStimulus(1'b0, 16'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
